// File: rtl/cu_pkg.sv
// Shared types and defaults for the compute-unit read command arbiter.
package cu_pkg;

  localparam int unsigned CU_READ_ARB_NUM_REQUESTERS  = 4;
  localparam int unsigned CU_READ_ARB_MAX_OUTSTANDING = 16;

  localparam int unsigned CU_ID_BITS   = 8;
  localparam int unsigned CU_ADDR_BITS = 32;
  localparam int unsigned CU_TAG_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2
  } cu_read_arb_state;

  typedef struct packed {
    logic                    valid;
    logic [CU_ID_BITS-1:0]   cu_id;
    logic [CU_ADDR_BITS-1:0] address;
    logic [CU_TAG_BITS-1:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
  } BufferStatus;

endpackage

// File: rtl/cu_read_command_arbiter_select.sv
// Combinational round-robin pick: first eligible requester at or after ptr wins.
module cu_round_robin_select #(
  parameter int unsigned N        = 4,
  parameter int unsigned PTR_BITS = 2
) (
  input  logic [N-1:0]        eligible,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [PTR_BITS-1:0] next_ptr
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && eligible[PTR_BITS'(idx)]) begin
        found                  = 1'b1;
        grant[PTR_BITS'(idx)]  = 1'b1;
        next_ptr               = (idx == N - 1) ? '0 : PTR_BITS'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Round-robin arbiter sharing the read command buffer with per-requester credits.
// Optional grant statistics enabled by defining CU_READ_ARB_STATS_EN.
module cu_read_command_arbiter
  import cu_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS  = CU_READ_ARB_NUM_REQUESTERS,
  parameter int unsigned MAX_OUTSTANDING = CU_READ_ARB_MAX_OUTSTANDING,
  parameter int unsigned CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled_in,
  input  CommandBufferLine          command_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] grant_out,
  input  BufferStatus               read_command_buffer_status,
  output CommandBufferLine          read_command_out,
  input  ResponseBufferLine         read_response_in,
  output logic [CNT_BITS-1:0]       outstanding_out [NUM_REQUESTERS],
  output logic                      drained_out,
  output logic                      credit_error_out
`ifdef CU_READ_ARB_STATS_EN
  ,
  output logic [31:0]               grant_count_out [NUM_REQUESTERS]
`endif
);

  localparam int unsigned PTR_BITS = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  cu_read_arb_state          state_q, state_d;
  logic [PTR_BITS-1:0]       rr_ptr_q, rr_ptr_next;
  logic [CNT_BITS-1:0]       cnt_q [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] eligible, resp_hit, credit_err, grant;
  logic                      all_zero;
  CommandBufferLine          granted_line;
  logic                      unused_resp;

  // Only the response valid and cu_id matter for credit return.
  assign unused_resp = ^{read_response_in.cmd.valid, read_response_in.cmd.address,
                         read_response_in.cmd.tag};

  always_comb begin
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enabled_in) state_d = ARB;
      ARB:     if (!enabled_in) state_d = DRAIN;
      DRAIN: begin
        if (enabled_in)    state_d = ARB;
        else if (all_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable is qualified combinationally so a falling enable stops grants that cycle.
  always_comb begin
    eligible   = '0;
    resp_hit   = '0;
    credit_err = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      eligible[i]   = (state_q == ARB) && enabled_in && !read_command_buffer_status.alfull &&
                      command_in[i].valid && (cnt_q[i] < CNT_BITS'(MAX_OUTSTANDING));
      resp_hit[i]   = read_response_in.valid &&
                      (read_response_in.cmd.cu_id == CU_ID_BITS'(i));
      credit_err[i] = resp_hit[i] && !grant[i] && (cnt_q[i] == '0);
    end
  end

  cu_round_robin_select #(
    .N        (NUM_REQUESTERS),
    .PTR_BITS (PTR_BITS)
  ) u_select (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .next_ptr (rr_ptr_next)
  );

  assign grant_out = grant;

  always_comb begin
    granted_line = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) granted_line = command_in[i];
    end
    if (|grant) granted_line.valid = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rstn) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      read_command_out <= '0;
      credit_error_out <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_next;
      read_command_out <= granted_line;
      if (|credit_err) credit_error_out <= 1'b1;
    end
  end

  // Grant and matching response in the same cycle cancel out.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (rstn) begin
        cnt_q[i] <= '0;
      end else if (grant[i] && !resp_hit[i]) begin
        cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
      end else if (!grant[i] && resp_hit[i] && (cnt_q[i] != '0)) begin
        cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
      end
    end
  end

  assign outstanding_out = cnt_q;
  assign drained_out     = (state_q == IDLE) && all_zero;

`ifdef CU_READ_ARB_STATS_EN
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (rstn)          grant_count_out[i] <= '0;
      else if (grant[i]) grant_count_out[i] <= grant_count_out[i] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Bench for cu_read_command_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_cu_read_command_arbiter;
  import cu_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 16;
  localparam int CB   = 5;

  logic              clock = 1'b0;
  logic              rstn;
  logic              enabled_in;
  CommandBufferLine  command_in [N];
  logic [N-1:0]      grant_out;
  BufferStatus       status;
  CommandBufferLine  read_command_out;
  ResponseBufferLine resp;
  logic [CB-1:0]     outstanding_out [N];
  logic              drained_out;
  logic              credit_error_out;
`ifdef CU_READ_ARB_STATS_EN
  logic [31:0]       grant_count_out [N];
`endif

  cu_read_command_arbiter dut (
    .clock                      (clock),
    .rstn                       (rstn),
    .enabled_in                 (enabled_in),
    .command_in                 (command_in),
    .grant_out                  (grant_out),
    .read_command_buffer_status (status),
    .read_command_out           (read_command_out),
    .read_response_in           (resp),
    .outstanding_out            (outstanding_out),
    .drained_out                (drained_out),
    .credit_error_out           (credit_error_out)
`ifdef CU_READ_ARB_STATS_EN
    ,
    .grant_count_out            (grant_count_out)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: mode 0 idle / 1 arbitrating / 2 draining.
  int               m_mode;
  int               m_ptr;
  int               m_cnt [N];
  int unsigned      m_gc [N];
  logic             m_err;
  CommandBufferLine m_out;
  int               last_w;
  int               n_err = 0;
  int               n_chk = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner();
    int j;
    if (m_mode != 1 || !enabled_in || status.alfull) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (command_in[j].valid && m_cnt[j] < MAXO) return j;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    int r;
    bit z;
    if (rstn) begin
      m_mode = 0; m_ptr = 0; m_err = 1'b0; m_out = '0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_gc[i] = 0; end
      return;
    end
    w = m_winner();
    r = -1;
    if (resp.valid && resp.cmd.cu_id < N) r = int'(resp.cmd.cu_id);
    z = 1'b1;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) z = 1'b0;
    if (w >= 0) begin
      m_out = command_in[w]; m_out.valid = 1'b1;
      m_ptr = (w + 1) % N;
      m_gc[w]++;
    end else begin
      m_out = '0;
    end
    if (r >= 0 && r != w) begin
      if (m_cnt[r] == 0) m_err = 1'b1;
      else m_cnt[r]--;
    end
    if (w >= 0 && w != r) m_cnt[w]++;
    case (m_mode)
      0: if (enabled_in) m_mode = 1;
      1: if (!enabled_in) m_mode = 2;
      default: if (enabled_in) m_mode = 1; else if (z) m_mode = 0;
    endcase
  endtask

  task automatic check_all(string tag);
    int w;
    logic [N-1:0] eg;
    logic all0;
    w = m_winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all0 = 1'b0;
    chk({tag, ".grant"}, 64'(grant_out), 64'(eg));
    chk({tag, ".cmd_out"}, 64'(read_command_out), 64'(m_out));
    for (int i = 0; i < N; i++)
      chk({tag, ".outstanding"}, 64'(outstanding_out[i]), 64'(m_cnt[i]));
    chk({tag, ".drained"}, 64'(drained_out), 64'(m_mode == 0 && all0));
    chk({tag, ".credit_err"}, 64'(credit_error_out), 64'(m_err));
`ifdef CU_READ_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk({tag, ".gcount"}, 64'(grant_count_out[i]), 64'(m_gc[i]));
`endif
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle(string tag);
    #1;
    check_all(tag);
    last_w = m_winner();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  function automatic CommandBufferLine mk(int i);
    CommandBufferLine l;
    l.valid   = 1'b1;
    l.cu_id   = 8'(i);
    l.address = $urandom;
    l.tag     = 8'($urandom);
    return l;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) command_in[i] = '0;
    resp   = '0;
    status = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    enabled_in = 1'b0;
    rstn = 1'b1;
    cycle("reset");
    rstn = 1'b0;
  endtask

  task automatic respond(int id);
    resp = '0;
    resp.valid = 1'b1;
    resp.cmd.cu_id = 8'(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int k;
    int r;
    logic [N-1:0] oh;
    clear_inputs();
    enabled_in = 1'b0;
    rstn = 1'b1;
    m_mode = 0; m_ptr = 0; m_err = 1'b0; m_out = '0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_gc[i] = 0; end
    @(negedge clock);
    cycle("reset");
    cycle("reset");
    rstn = 1'b0;
    #1;
    chk("rst_drained", 64'(drained_out), 64'(1));
    chk("rst_grant", 64'(grant_out), 64'(0));
    chk("rst_cmd_valid", 64'(read_command_out.valid), 64'(0));
    chk("rst_credit_err", 64'(credit_error_out), 64'(0));

    // Round-robin fairness with immediate responses.
    enabled_in = 1'b1;
    cycle("fair_en");
    for (int i = 0; i < N; i++) command_in[i] = mk(i);
    for (int c = 0; c < 16; c++) begin
      resp = '0;
      if (c > 0) respond((c - 1) % N);
      #1;
      oh = '0; oh[c % N] = 1'b1;
      chk("fair_grant", 64'(grant_out), 64'(oh));
      if (c > 0) begin
        chk("fair_out_valid", 64'(read_command_out.valid), 64'(1));
        chk("fair_out_id", 64'(read_command_out.cu_id), 64'((c - 1) % N));
      end
      cycle("fair");
    end

    // Credit limit on a single requester.
    do_reset();
    enabled_in = 1'b1;
    cycle("credit_en");
    command_in[2] = mk(2);
    g = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (grant_out[2]) g++;
      cycle("credit");
    end
    chk("credit_grants", 64'(g), 64'(16));
    chk("credit_cnt16", 64'(outstanding_out[2]), 64'(16));
    respond(2);
    #1 chk("credit_blocked", 64'(grant_out), 64'(0));
    cycle("credit_resp");
    resp = '0;
    #1 chk("credit_regrant", 64'(grant_out), 64'(4'b0100));
    cycle("credit_regrant");
    #1 chk("credit_once", 64'(grant_out), 64'(0));
    cycle("credit_after");

    // Grant and response for the same requester in one cycle.
    do_reset();
    enabled_in = 1'b1;
    cycle("sim_en");
    command_in[1] = mk(1);
    repeat (5) cycle("sim_fill");
    chk("sim_cnt5", 64'(outstanding_out[1]), 64'(5));
    respond(1);
    #1 chk("sim_grant", 64'(grant_out), 64'(4'b0010));
    cycle("sim_both");
    resp = '0;
    command_in[1].valid = 1'b0;
    #1 chk("sim_cnt_hold", 64'(outstanding_out[1]), 64'(5));

    // Backpressure holds the pointer.
    do_reset();
    enabled_in = 1'b1;
    cycle("bp_en");
    for (int i = 0; i < N; i++) command_in[i] = mk(i);
    cycle("bp_pre");
    cycle("bp_pre");
    status.alfull = 1'b1;
    repeat (3) begin
      #1 chk("bp_nogrant", 64'(grant_out), 64'(0));
      cycle("bp_full");
    end
    status.alfull = 1'b0;
    #1 chk("bp_resume", 64'(grant_out), 64'(4'b0100));
    cycle("bp_resume");

    // Drain to idle.
    do_reset();
    enabled_in = 1'b1;
    cycle("drain_en");
    command_in[0] = mk(0);
    repeat (3) cycle("drain_fill");
    command_in[0].valid = 1'b1;
    enabled_in = 1'b0;
    #1 chk("drain_nogrant", 64'(grant_out), 64'(0));
    cycle("drain_off");
    command_in[0] = '0;
    chk("drain_not_idle", 64'(drained_out), 64'(0));
    for (int c = 0; c < 3; c++) begin
      respond(0);
      cycle("drain_resp");
    end
    resp = '0;
    k = 0;
    #1;
    while (drained_out !== 1'b1 && k < 6) begin
      cycle("drain_wait");
      k++;
    end
    chk("drain_done", 64'(drained_out), 64'(1));
    chk("drain_latency", 64'(k), 64'(1));

    // Mid-stream reset then a stray response.
    do_reset();
    enabled_in = 1'b1;
    cycle("rs_en");
    command_in[0] = mk(0);
    repeat (4) cycle("rs_fill0");
    command_in[0] = '0; command_in[1] = mk(1);
    repeat (2) cycle("rs_fill1");
    command_in[1] = '0; command_in[3] = mk(3);
    repeat (7) cycle("rs_fill3");
    chk("rs_cnt0", 64'(outstanding_out[0]), 64'(4));
    chk("rs_cnt1", 64'(outstanding_out[1]), 64'(2));
    chk("rs_cnt2", 64'(outstanding_out[2]), 64'(0));
    chk("rs_cnt3", 64'(outstanding_out[3]), 64'(7));
    for (int i = 0; i < N; i++) command_in[i] = mk(i);
    rstn = 1'b1;
    cycle("rs_reset");
    rstn = 1'b0;
    clear_inputs();
    #1;
    for (int i = 0; i < N; i++) chk("rs_cnt_zero", 64'(outstanding_out[i]), 64'(0));
    chk("rs_out_valid", 64'(read_command_out.valid), 64'(0));
    chk("rs_drained", 64'(drained_out), 64'(1));
    respond(0);
    cycle("rs_stray");
    resp = '0;
    #1 chk("rs_credit_err", 64'(credit_error_out), 64'(1));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enabled_in    = ($urandom_range(0, 9) != 0);
      status.alfull = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++)
        if (!command_in[i].valid && $urandom_range(0, 2) == 0) command_in[i] = mk(i);
      resp = '0;
      r = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        if (r < N && m_cnt[r] > 0) respond(r);
        else if (r >= N) respond(int'($urandom_range(N, 255)));
      end
      rstn = ($urandom_range(0, 149) == 0);
      cycle("rand");
      if (last_w >= 0) command_in[last_w].valid = 1'b0;
    end
    rstn = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cu_read_command_arbiter.md
# cu_read_command_arbiter

Shares the compute unit's single read command buffer among `NUM_REQUESTERS` read engines. Each cycle it grants at most one requester in round-robin order, registers the granted `CommandBufferLine` toward the read command buffer, and throttles each requester with a per-requester outstanding-read credit counter. Credits are returned by `read_response_in`. The block sits between the per-engine read control logic and the AFU read command buffer.

## Interface
Parameters:
- `NUM_REQUESTERS`, default 4: number of read engines sharing the buffer.
- `MAX_OUTSTANDING`, default 16: outstanding-read limit per requester (≥1).
- `CNT_BITS`, default `$clog2(MAX_OUTSTANDING+1)`: width of each credit counter.

Ports:
- `clock`  in  1: the single clock. All logic is on the rising edge.
- `rstn`  in  1: reset, **synchronous, active-high**.
- `enabled_in`  in  1: arbiter enable.
- `command_in[NUM_REQUESTERS]`  in  `CommandBufferLine`: request from each engine. Uses the `.valid` and `.cu_id` fields.
- `grant_out`  out  `NUM_REQUESTERS`: one-hot acceptance of `command_in[i]` in the current cycle.
- `read_command_buffer_status`  in  `BufferStatus`: `.alfull` blocks issue.
- `read_command_out`  out  `CommandBufferLine`: registered granted command.
- `read_response_in`  in  `ResponseBufferLine`: `.valid` and `.cmd.cu_id` return one credit.
- `outstanding_out[NUM_REQUESTERS]`  out  `CNT_BITS`: current credit counters.
- `drained_out`  out  1: high in IDLE when all counters are 0.
- `credit_error_out`  out  1: sticky flag, set on a response for a requester whose counter is 0.

## Operation
The FSM has three states: IDLE, ARB and DRAIN.
- IDLE → ARB when `enabled_in`=1.
- ARB → DRAIN when `enabled_in`=0.
- DRAIN → IDLE when all counters are 0.
- DRAIN → ARB when `enabled_in` is reasserted.
- No grants are issued in IDLE or DRAIN. Responses are processed in every state.

A requester `i` is eligible only when all of the following hold: the state is ARB; `command_in[i].valid`; `outstanding[i] < MAX_OUTSTANDING`; and `read_command_buffer_status.alfull`=0.

Round-robin selection:
- Among eligible requesters, the first at or after `rr_ptr` (wrapping modulo `NUM_REQUESTERS`) wins.
- On a grant, `rr_ptr` ← winner+1, wrapping to 0 after `NUM_REQUESTERS-1`.
- With no grant, `rr_ptr` holds.

Handshake:
- A requester holds `command_in[i]` stable until `grant_out[i]`=1 in the same cycle.
- `grant_out` is combinational from the registered state and the inputs.

Credit counters:
- Increment on grant to `i`.
- Decrement on a valid response whose `cu_id`=i.
- If both happen in the same cycle for the same `i`, the counter is unchanged.
- A decrement at 0 is suppressed and sets `credit_error_out`.
- Responses with `cu_id` ≥ `NUM_REQUESTERS` are ignored.

`read_command_out` is a copy of the granted line with `.valid`=1. With no grant it is all-zero, `.valid`=0.

## Timing
- Grant to `read_command_out.valid`: 1 cycle.
- Throughput: 1 command per cycle.
- Response to counter update: visible on `outstanding_out` 1 cycle later. The freed credit can be granted in that following cycle.
- `alfull` sampled high blocks a grant in the same cycle. There is no skid.
- `enabled_in` falling: no grant from that cycle onward. A command already registered still emits on the next cycle.

Reset (`rstn`=1 at an edge), whether idle or mid-operation:
- State → IDLE, `rr_ptr` → 0, all counters → 0.
- `read_command_out` → 0, `credit_error_out` → 0.
- `grant_out` → 0 and `drained_out` → 1 on the cycle after reset.
- In-flight responses after reset decrement nothing and set `credit_error_out`.

## Configuration
- `CU_READ_ARB_STATS_EN` defined: adds output `grant_count_out[NUM_REQUESTERS]`, 32-bit each.
  - Each count increments on every grant and wraps at 2^32.
  - Reset to 0; not cleared by DRAIN.
- Macro undefined: the port and its counters are absent. All other behaviour is identical.

## Structure
- `CU_PKG` holds `CU_READ_ARB_NUM_REQUESTERS`, `CU_READ_ARB_MAX_OUTSTANDING` and the `cu_read_arb_state` enum (IDLE/ARB/DRAIN).
- One sub-module, `cu_round_robin_select`. It is combinational: eligible vector + pointer in, one-hot grant and next pointer out. The pointer register stays in the parent.

## Test plan
- **Round-robin fairness:** all 4 requesters valid continuously, `alfull`=0, `MAX_OUTSTANDING`=16, responses returned immediately → grants cycle 0,1,2,3,0… over 16 cycles, with each `read_command_out` one cycle after its grant.
- **Credit limit:** requester 2 alone for 20 cycles, no responses → exactly 16 grants, then `grant_out` stays 0 and `outstanding_out[2]`=16. One response with `cu_id`=2 → exactly one more grant on the following cycle.
- **Simultaneous events:** grant to 1 and response for 1 in the same cycle, `outstanding[1]`=5 → stays 5.
- **Backpressure:** `alfull`=1 for 3 cycles with all requesters valid → zero grants and `rr_ptr` unchanged. On release, grants resume at the prior pointer.
- **Drain:** 3 outstanding reads, then `enabled_in`=0 → state DRAIN, no grants. After the 3rd response → IDLE and `drained_out`=1.
- **Reset and stray responses:** `rstn`=1 mid-stream with counters {4,2,0,7} → all 0 and `read_command_out.valid`=0 the next cycle. A following response for requester 0 sets `credit_error_out`=1.
